// File: rtl/rover_nav_sequencer.sv
// Rover navigation sequencer: synchronised line/obstacle arbitration driving a registered motor command.
// Optional input debounce filter is enabled by defining NAV_DEBOUNCE_EN.
module rover_nav_sequencer #(
  parameter int CNT_W           = 16,
  parameter int REV_CYCLES      = 2000,
  parameter int TURN_CYCLES     = 3000,
  parameter int FWD_CYCLES      = 5000,
  parameter int REACQ_CYCLES    = 8000,
  parameter int LOST_CYCLES     = 4000,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] induct,
  input  logic       proxim,
  output logic [3:0] motor_cmd,
  output logic [2:0] state_out,
  output logic       avoid_active,
  output logic       line_lost
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FOLLOW     = 3'd1,
    S_AVOID_REV  = 3'd2,
    S_AVOID_TURN = 3'd3,
    S_AVOID_FWD  = 3'd4,
    S_REACQUIRE  = 3'd5,
    S_LOST       = 3'd6
  } state_t;

  typedef enum logic {
    TURN_LEFT  = 1'b0,
    TURN_RIGHT = 1'b1
  } turn_t;

  localparam logic [3:0] M_STOP  = 4'b0000;
  localparam logic [3:0] M_FWD   = 4'b0110;
  localparam logic [3:0] M_LEFT  = 4'b1010;
  localparam logic [3:0] M_RIGHT = 4'b0101;
  localparam logic [3:0] M_REV   = 4'b1001;

  localparam logic [CNT_W-1:0] REV_LAST   = CNT_W'(REV_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] FWD_LAST   = CNT_W'(FWD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REACQ_LAST = CNT_W'(REACQ_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOST_LIMIT = CNT_W'(LOST_CYCLES);

  localparam longint CNT_SPAN = longint'(1) << CNT_W;

  if (REV_CYCLES < 1 || longint'(REV_CYCLES) >= CNT_SPAN ||
      TURN_CYCLES < 1 || longint'(TURN_CYCLES) >= CNT_SPAN ||
      FWD_CYCLES < 1 || longint'(FWD_CYCLES) >= CNT_SPAN ||
      REACQ_CYCLES < 1 || longint'(REACQ_CYCLES) >= CNT_SPAN ||
      LOST_CYCLES < 1 || longint'(LOST_CYCLES) >= CNT_SPAN ||
      DEBOUNCE_CYCLES < 2) begin : g_bad_params
    $error("rover_nav_sequencer: cycle parameter out of range");
  end

  logic [2:0] induct_s1, induct_s2, induct_f;
  logic       proxim_s1, proxim_s2, proxim_f;

  always_ff @(posedge clk) begin
    if (reset) begin
      induct_s1 <= '0;
      induct_s2 <= '0;
      proxim_s1 <= 1'b0;
      proxim_s2 <= 1'b0;
    end else begin
      induct_s1 <= induct;
      induct_s2 <= induct_s1;
      proxim_s1 <= proxim;
      proxim_s2 <= proxim_s1;
    end
  end

`ifdef NAV_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]      induct_cand;
  logic [DB_W-1:0] induct_dcnt;
  logic            proxim_cand;
  logic [DB_W-1:0] proxim_dcnt;

  // The first cycle a new value differs from its predecessor counts as stable cycle 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      induct_cand <= '0;
      induct_dcnt <= '0;
      induct_f    <= '0;
      proxim_cand <= 1'b0;
      proxim_dcnt <= '0;
      proxim_f    <= 1'b0;
    end else begin
      induct_cand <= induct_s2;
      if (induct_s2 == induct_f) induct_dcnt <= '0;
      else if (induct_s2 != induct_cand) induct_dcnt <= DB_W'(1);
      else if (induct_dcnt == DB_LAST) begin
        induct_f    <= induct_s2;
        induct_dcnt <= '0;
      end else induct_dcnt <= induct_dcnt + 1'b1;

      proxim_cand <= proxim_s2;
      if (proxim_s2 == proxim_f) proxim_dcnt <= '0;
      else if (proxim_s2 != proxim_cand) proxim_dcnt <= DB_W'(1);
      else if (proxim_dcnt == DB_LAST) begin
        proxim_f    <= proxim_s2;
        proxim_dcnt <= '0;
      end else proxim_dcnt <= proxim_dcnt + 1'b1;
    end
  end
`else
  always_comb begin
    induct_f = induct_s2;
    proxim_f = proxim_s2;
  end
`endif

  state_t           state, state_nx;
  turn_t            last_turn, last_turn_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic [3:0]       motor_nx;
  logic             line_seen;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      last_turn <= TURN_LEFT;
      motor_cmd <= M_STOP;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      last_turn <= last_turn_nx;
      motor_cmd <= motor_nx;
    end
  end

  // Motor command is registered from the state being entered, so it stays aligned with state_out.
  always_comb begin
    state_nx     = state;
    last_turn_nx = last_turn;
    motor_nx     = M_STOP;
    line_seen    = (induct_f != 3'b000);
    cnt_inc      = (cnt == '1) ? cnt : cnt + 1'b1;
    cnt_nx       = cnt_inc;

    case (state)
      S_IDLE:   state_nx = S_FOLLOW;
      S_FOLLOW: begin
        if (proxim_f) state_nx = S_AVOID_REV;
        else if (line_seen) cnt_nx = '0;
        else if (cnt == LOST_LIMIT) state_nx = S_LOST;
      end
      S_AVOID_REV:  if (cnt == REV_LAST) state_nx = S_AVOID_TURN;
      S_AVOID_TURN: if (cnt == TURN_LAST) state_nx = S_AVOID_FWD;
      S_AVOID_FWD: begin
        if (proxim_f) state_nx = S_AVOID_REV;
        else if (cnt == FWD_LAST) state_nx = S_REACQUIRE;
      end
      S_REACQUIRE: begin
        if (proxim_f) state_nx = S_AVOID_REV;
        else if (cnt == REACQ_LAST) state_nx = S_LOST;
        else if (line_seen) state_nx = S_FOLLOW;
      end
      S_LOST:  if (line_seen) state_nx = S_FOLLOW;
      default: state_nx = S_IDLE;
    endcase

    if (!enable) state_nx = S_IDLE;
    if (state_nx != state || state_nx == S_IDLE || state_nx == S_LOST) cnt_nx = '0;

    case (state_nx)
      S_FOLLOW: begin
        case (induct_f)
          3'b010, 3'b111, 3'b101: motor_nx = M_FWD;
          3'b100, 3'b110: begin
            motor_nx     = M_LEFT;
            last_turn_nx = TURN_LEFT;
          end
          3'b001, 3'b011: begin
            motor_nx     = M_RIGHT;
            last_turn_nx = TURN_RIGHT;
          end
          default: motor_nx = (last_turn == TURN_RIGHT) ? M_RIGHT : M_LEFT;
        endcase
      end
      S_AVOID_REV:  motor_nx = M_REV;
      S_AVOID_TURN: motor_nx = M_RIGHT;
      S_AVOID_FWD:  motor_nx = M_FWD;
      S_REACQUIRE:  motor_nx = M_LEFT;
      default:      motor_nx = M_STOP;
    endcase
  end

  always_comb begin
    state_out    = state;
    avoid_active = (state == S_AVOID_REV) || (state == S_AVOID_TURN) ||
                   (state == S_AVOID_FWD) || (state == S_REACQUIRE);
    line_lost    = (state == S_LOST);
  end

endmodule

// File: tb/tb_rover_nav_sequencer.sv
// Directed self-checking bench for rover_nav_sequencer with short manoeuvre timings.
// Define NAV_DEBOUNCE_EN to exercise the debounce filter scenario instead of the main sequence.
module tb_rover_nav_sequencer;

  localparam logic [3:0] STOP  = 4'b0000;
  localparam logic [3:0] FWD   = 4'b0110;
  localparam logic [3:0] LEFT  = 4'b1010;
  localparam logic [3:0] RIGHT = 4'b0101;
  localparam logic [3:0] REV   = 4'b1001;

  logic       clk = 1'b0;
  logic       reset, enable, proxim;
  logic [2:0] induct;
  logic [3:0] motor_cmd;
  logic [2:0] state_out;
  logic       avoid_active, line_lost;

  int checks = 0;
  int passes = 0;

  rover_nav_sequencer #(
    .CNT_W(16), .REV_CYCLES(4), .TURN_CYCLES(6), .FWD_CYCLES(8),
    .REACQ_CYCLES(10), .LOST_CYCLES(5), .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .induct(induct), .proxim(proxim),
    .motor_cmd(motor_cmd), .state_out(state_out),
    .avoid_active(avoid_active), .line_lost(line_lost)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; induct = 3'b010; proxim = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      checks++;
      if ({state_out, motor_cmd, avoid_active, line_lost} !== {3'd0, STOP, 1'b0, 1'b0})
        $display("FAIL reset_vals cyc=%0d got st=%0d m=%b av=%b ll=%b exp st=0 m=0000 av=0 ll=0",
                 i, state_out, motor_cmd, avoid_active, line_lost);
      else passes++;
    end
    reset = 1'b0;
    tick(1);
    checks++;
    if (state_out !== 3'd1) $display("FAIL reset_release got st=%0d exp 1", state_out);
    else passes++;
  endtask

  task automatic test_follow;
    logic [2:0] vin  [7];
    logic [3:0] vexp [7];
    logic [3:0] prev;
    vin  = '{3'b100, 3'b001, 3'b010, 3'b110, 3'b011, 3'b111, 3'b101};
    vexp = '{LEFT, RIGHT, FWD, LEFT, RIGHT, FWD, FWD};
    tick(2);
    checks++;
    if ({state_out, motor_cmd} !== {3'd1, FWD})
      $display("FAIL follow_start got st=%0d m=%b exp st=1 m=%b", state_out, motor_cmd, FWD);
    else passes++;
    prev = FWD;
    for (int i = 0; i < 7; i++) begin
      induct = vin[i];
      tick(2);
      checks++;
      if (motor_cmd !== prev)
        $display("FAIL follow_hold in=%b got m=%b exp m=%b", vin[i], motor_cmd, prev);
      else passes++;
      tick(1);
      checks++;
      if ({state_out, motor_cmd} !== {3'd1, vexp[i]})
        $display("FAIL follow_cmd in=%b got st=%0d m=%b exp st=1 m=%b",
                 vin[i], state_out, motor_cmd, vexp[i]);
      else passes++;
      prev = vexp[i];
    end
  endtask

  task automatic test_avoid;
    induct = 3'b000; proxim = 1'b1;
    tick(1);
    proxim = 1'b0;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({state_out, motor_cmd, avoid_active} !== {3'd2, REV, 1'b1})
        $display("FAIL avoid_rev cyc=%0d got st=%0d m=%b av=%b exp st=2 m=%b av=1",
                 i, state_out, motor_cmd, avoid_active, REV);
      else passes++;
      tick(1);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({state_out, motor_cmd} !== {3'd3, RIGHT})
        $display("FAIL avoid_turn cyc=%0d got st=%0d m=%b exp st=3 m=%b", i, state_out, motor_cmd, RIGHT);
      else passes++;
      tick(1);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({state_out, motor_cmd} !== {3'd4, FWD})
        $display("FAIL avoid_fwd cyc=%0d got st=%0d m=%b exp st=4 m=%b", i, state_out, motor_cmd, FWD);
      else passes++;
      tick(1);
    end
    checks++;
    if ({state_out, motor_cmd, avoid_active} !== {3'd5, LEFT, 1'b1})
      $display("FAIL reacq_entry got st=%0d m=%b av=%b exp st=5 m=%b av=1",
               state_out, motor_cmd, avoid_active, LEFT);
    else passes++;
    induct = 3'b010;
    tick(2);
    checks++;
    if ({state_out, motor_cmd} !== {3'd5, LEFT})
      $display("FAIL reacq_hold got st=%0d m=%b exp st=5 m=%b", state_out, motor_cmd, LEFT);
    else passes++;
    tick(1);
    checks++;
    if ({state_out, motor_cmd, avoid_active} !== {3'd1, FWD, 1'b0})
      $display("FAIL reacq_found got st=%0d m=%b av=%b exp st=1 m=%b av=0",
               state_out, motor_cmd, avoid_active, FWD);
    else passes++;
  endtask

  task automatic test_lost;
    induct = 3'b000;
    tick(2);
    checks++;
    if (motor_cmd !== FWD) $display("FAIL lost_pre got m=%b exp m=%b", motor_cmd, FWD);
    else passes++;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({state_out, motor_cmd, line_lost} !== {3'd1, RIGHT, 1'b0})
        $display("FAIL lost_last_turn cyc=%0d got st=%0d m=%b ll=%b exp st=1 m=%b ll=0",
                 i, state_out, motor_cmd, line_lost, RIGHT);
      else passes++;
      tick(1);
    end
    checks++;
    if ({state_out, motor_cmd, line_lost} !== {3'd6, STOP, 1'b1})
      $display("FAIL lost_entry got st=%0d m=%b ll=%b exp st=6 m=0000 ll=1", state_out, motor_cmd, line_lost);
    else passes++;
    proxim = 1'b1;
    tick(1);
    proxim = 1'b0;
    tick(3);
    checks++;
    if ({state_out, motor_cmd} !== {3'd6, STOP})
      $display("FAIL lost_ignores_proxim got st=%0d m=%b exp st=6 m=0000", state_out, motor_cmd);
    else passes++;
    induct = 3'b001;
    tick(3);
    checks++;
    if ({state_out, motor_cmd, line_lost} !== {3'd1, RIGHT, 1'b0})
      $display("FAIL lost_recover got st=%0d m=%b ll=%b exp st=1 m=%b ll=0",
               state_out, motor_cmd, line_lost, RIGHT);
    else passes++;
  endtask

  task automatic test_restart;
    induct = 3'b000; proxim = 1'b1;
    tick(1);
    proxim = 1'b0;
    tick(12);
    checks++;
    if ({state_out, motor_cmd} !== {3'd4, FWD})
      $display("FAIL restart_fwd1 got st=%0d m=%b exp st=4 m=%b", state_out, motor_cmd, FWD);
    else passes++;
    proxim = 1'b1;
    tick(1);
    proxim = 1'b0;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({state_out, motor_cmd} !== {3'd2, REV})
        $display("FAIL restart_rev cyc=%0d got st=%0d m=%b exp st=2 m=%b", i, state_out, motor_cmd, REV);
      else passes++;
      tick(1);
    end
    checks++;
    if ({state_out, motor_cmd} !== {3'd3, RIGHT})
      $display("FAIL restart_turn got st=%0d m=%b exp st=3 m=%b", state_out, motor_cmd, RIGHT);
    else passes++;
    tick(6);
    checks++;
    if (state_out !== 3'd4) $display("FAIL restart_fwd2 got st=%0d exp 4", state_out);
    else passes++;
    proxim = 1'b1;
    tick(2);
    checks++;
    if (state_out !== 3'd4) $display("FAIL prio_pre got st=%0d exp 4", state_out);
    else passes++;
    enable = 1'b0;
    tick(1);
    proxim = 1'b0;
    checks++;
    if ({state_out, motor_cmd, avoid_active} !== {3'd0, STOP, 1'b0})
      $display("FAIL prio_enable got st=%0d m=%b av=%b exp st=0 m=0000 av=0", state_out, motor_cmd, avoid_active);
    else passes++;
    tick(1);
    checks++;
    if ({state_out, motor_cmd} !== {3'd0, STOP})
      $display("FAIL idle_hold got st=%0d m=%b exp st=0 m=0000", state_out, motor_cmd);
    else passes++;
    enable = 1'b1;
    tick(1);
    checks++;
    if (state_out !== 3'd1) $display("FAIL idle_exit got st=%0d exp 1", state_out);
    else passes++;
  endtask

  task automatic test_reacq_timeout;
    proxim = 1'b1;
    tick(1);
    proxim = 1'b0;
    tick(2);
    checks++;
    if (state_out !== 3'd2) $display("FAIL to_rev got st=%0d exp 2", state_out);
    else passes++;
    tick(18);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({state_out, motor_cmd} !== {3'd5, LEFT})
        $display("FAIL reacq_search cyc=%0d got st=%0d m=%b exp st=5 m=%b", i, state_out, motor_cmd, LEFT);
      else passes++;
      tick(1);
    end
    checks++;
    if ({state_out, motor_cmd, line_lost, avoid_active} !== {3'd6, STOP, 1'b1, 1'b0})
      $display("FAIL reacq_timeout got st=%0d m=%b ll=%b av=%b exp st=6 m=0000 ll=1 av=0",
               state_out, motor_cmd, line_lost, avoid_active);
    else passes++;
  endtask

  task automatic test_proxim_latency;
`ifdef NAV_DEBOUNCE_EN
    tick(20);
    checks++;
    if ({state_out, motor_cmd} !== {3'd1, FWD})
      $display("FAIL db_follow got st=%0d m=%b exp st=1 m=%b", state_out, motor_cmd, FWD);
    else passes++;
    proxim = 1'b1;
    tick(3);
    proxim = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checks++;
      if ({state_out, motor_cmd} !== {3'd1, FWD})
        $display("FAIL db_glitch cyc=%0d got st=%0d m=%b exp st=1 m=%b", i, state_out, motor_cmd, FWD);
      else passes++;
    end
    proxim = 1'b1;
    tick(10);
    proxim = 1'b0;
    checks++;
    if (state_out !== 3'd1) $display("FAIL db_pre_avoid got st=%0d exp 1", state_out);
    else passes++;
    tick(1);
    checks++;
    if ({state_out, motor_cmd} !== {3'd2, REV})
      $display("FAIL db_avoid got st=%0d m=%b exp st=2 m=%b", state_out, motor_cmd, REV);
    else passes++;
`else
    induct = 3'b010;
    tick(3);
    checks++;
    if ({state_out, motor_cmd} !== {3'd1, FWD})
      $display("FAIL lat_follow got st=%0d m=%b exp st=1 m=%b", state_out, motor_cmd, FWD);
    else passes++;
    proxim = 1'b1;
    tick(2);
    checks++;
    if (state_out !== 3'd1) $display("FAIL lat_pre_avoid got st=%0d exp 1", state_out);
    else passes++;
    tick(1);
    proxim = 1'b0;
    checks++;
    if ({state_out, motor_cmd} !== {3'd2, REV})
      $display("FAIL lat_avoid got st=%0d m=%b exp st=2 m=%b", state_out, motor_cmd, REV);
    else passes++;
`endif
  endtask

  initial begin
    test_reset;
`ifndef NAV_DEBOUNCE_EN
    test_follow;
    test_avoid;
    test_lost;
    test_restart;
    test_reacq_timeout;
`endif
    test_proxim_latency;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
